stoch_to_binary: RTL and testbench

- Decodes a unipolar stochastic bitstream into a binary value. It is the consumer end of the bitstreams produced by the stochastic multiplier and adder stages.
- Counts the ones over a fixed power-of-two window of valid bits.
- Scales the count by the stream's carried nummax and returns {count, value, nummax} through a valid/ready output handshake.
- Sits at the tail of a stochastic datapath, before binary result capture.

---
 rtl/stoch_to_binary.sv | 164 ++++++++++++++++
 tb/tb_stoch_to_binary.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stoch_to_binary.sv
// ---------------------------------------------------------------------------
// stoch_to_binary
//
// Decodes a unipolar stochastic bitstream into a binary estimate. It counts
// the ones over a window of 2^WIN_LOG2 valid bits. It then scales that count
// by the full-scale value (nummax) carried with the stream. The result is
// returned as {count, value, nummax} through a valid/ready handshake.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   request to begin a window; latches nummax_in
//   nummax_in   in   full-scale value of the incoming stream
//   bit_in      in   stochastic stream bit
//   bit_valid   in   bit_in is sampled this cycle (ACCUM only)
//   busy        out  high while accumulating or holding a result
//   out_valid   out  result registers are valid
//   out_ready   in   downstream accepts the result
//   count       out  number of ones in the window (0..2^WIN_LOG2)
//   value       out  (count*nummax) >> WIN_LOG2, truncated or rounded
//   nummax_out  out  nummax that was latched for this window
// ---------------------------------------------------------------------------
module stoch_to_binary #(
    parameter int WIN_LOG2 = 8,
    parameter int NUM_W    = 9,
    parameter int ROUND    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_W-1:0]    nummax_in,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIN_LOG2:0]   count,
    output logic [NUM_W-1:0]    value,
    output logic [NUM_W-1:0]    nummax_out
);

    localparam int CW = WIN_LOG2 + 1;
    localparam int PW = WIN_LOG2 + 1 + NUM_W;

    // The sample counter equals this on the cycle that takes the final bit.
    localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << WIN_LOG2) - 1);

    // Half an LSB of the shifted result, added only when rounding is enabled.
    localparam logic [PW-1:0] ROUND_ADD =
        (ROUND != 0) ? (PW'(1) << (WIN_LOG2 - 1)) : '0;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      sampleCnt_q, sampleCnt_d;
    logic [CW-1:0]      onesCnt_q, onesCnt_d;
    logic [NUM_W-1:0]   nummaxLat_q, nummaxLat_d;
    logic [CW-1:0]      count_q, count_d;
    logic [NUM_W-1:0]   value_q, value_d;
    logic [NUM_W-1:0]   nummaxOut_q, nummaxOut_d;
    logic               outValid_q, outValid_d;

    logic [CW-1:0]      onesNext;
    logic [PW-1:0]      product;
    logic [PW-1:0]      rounded;
    logic [NUM_W-1:0]   scaledValue;
    logic               lastBit;

    // The scaling is computed from the ones total that includes the bit being
    // accepted. That way the result can be registered on the same edge that
    // takes the final bit. The product is wide enough that count=2^WIN_LOG2
    // gives exactly nummax after the shift, so no saturation is needed.
    always_comb begin
        onesNext    = onesCnt_q + CW'(bit_in);
        product     = PW'(onesNext) * PW'(nummaxLat_q);
        rounded     = product + ROUND_ADD;
        scaledValue = NUM_W'(rounded >> WIN_LOG2);
        lastBit     = (state_q == ACCUM) && bit_valid && (sampleCnt_q == LAST_SAMPLE);
    end

    // Next-state logic. In HOLD, a start that coincides with the transfer
    // opens the next window immediately, so windows can run back to back.
    always_comb begin
        state_d     = state_q;
        sampleCnt_d = sampleCnt_q;
        onesCnt_d   = onesCnt_q;
        nummaxLat_d = nummaxLat_q;
        count_d     = count_q;
        value_d     = value_q;
        nummaxOut_d = nummaxOut_q;
        outValid_d  = outValid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    nummaxLat_d = nummax_in;
                    sampleCnt_d = '0;
                    onesCnt_d   = '0;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (bit_valid) begin
                    sampleCnt_d = sampleCnt_q + CW'(1);
                    onesCnt_d   = onesNext;
                end
                if (lastBit) begin
                    count_d     = onesNext;
                    value_d     = scaledValue;
                    nummaxOut_d = nummaxLat_q;
                    outValid_d  = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (outValid_q && out_ready) begin
                    outValid_d = 1'b0;
                    if (start) begin
                        nummaxLat_d = nummax_in;
                        sampleCnt_d = '0;
                        onesCnt_d   = '0;
                        state_d     = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers. Reset discards any partial or pending
    // result and clears the visible outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sampleCnt_q <= '0;
            onesCnt_q   <= '0;
            nummaxLat_q <= '0;
            count_q     <= '0;
            value_q     <= '0;
            nummaxOut_q <= '0;
            outValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sampleCnt_q <= sampleCnt_d;
            onesCnt_q   <= onesCnt_d;
            nummaxLat_q <= nummaxLat_d;
            count_q     <= count_d;
            value_q     <= value_d;
            nummaxOut_q <= nummaxOut_d;
            outValid_q  <= outValid_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign out_valid  = outValid_q;
    assign count      = count_q;
    assign value      = value_q;
    assign nummax_out = nummaxOut_q;

endmodule

// File: tb/tb_stoch_to_binary.sv
// ---------------------------------------------------------------------------
// tb_stoch_to_binary
//
// Drives two decoders from the same stimulus: one that truncates and one that
// rounds. Each window's expected result is computed from the bit pattern by
// plain arithmetic and pushed into a queue. A monitor pops an entry whenever
// a new result is presented and compares it against both decoders.
// ---------------------------------------------------------------------------
module tb_stoch_to_binary;

    localparam int WIN_LOG2 = 4;
    localparam int NUM_W    = 9;
    localparam int WIN      = 1 << WIN_LOG2;

    typedef struct {
        int count;
        int value;
        int valueR;
        int nummax;
    } expect_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [NUM_W-1:0]    nummaxIn;
    logic                bitIn;
    logic                bitValid;
    logic                outReady;

    logic                busy, busyR;
    logic                outValid, outValidR;
    logic [WIN_LOG2:0]   count, countR;
    logic [NUM_W-1:0]    value, valueR;
    logic [NUM_W-1:0]    nummaxOut, nummaxOutR;

    expect_t             sb[$];
    int                  checks = 0;
    int                  errors = 0;

    stoch_to_binary #(.WIN_LOG2(WIN_LOG2), .NUM_W(NUM_W), .ROUND(0)) dut (
        .clk(clk), .rst(rst), .start(start), .nummax_in(nummaxIn),
        .bit_in(bitIn), .bit_valid(bitValid), .busy(busy),
        .out_valid(outValid), .out_ready(outReady), .count(count),
        .value(value), .nummax_out(nummaxOut)
    );

    stoch_to_binary #(.WIN_LOG2(WIN_LOG2), .NUM_W(NUM_W), .ROUND(1)) dutRound (
        .clk(clk), .rst(rst), .start(start), .nummax_in(nummaxIn),
        .bit_in(bitIn), .bit_valid(bitValid), .busy(busyR),
        .out_valid(outValidR), .out_ready(outReady), .count(countR),
        .value(valueR), .nummax_out(nummaxOutR)
    );

    always #5 clk = ~clk;

    // Reference: fraction of ones times full scale, in integer arithmetic.
    function automatic expect_t model(input logic [WIN-1:0] pattern, input int nm);
        expect_t e;
        e.count  = $countones(pattern);
        e.value  = (e.count * nm) / WIN;
        e.valueR = (e.count * nm + WIN / 2) / WIN;
        e.nummax = nm;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock of stimulus. Inputs change 1 time unit after the rising edge.
    task automatic applyStimulus(input logic s, input int nm, input logic v, input logic b);
        start    = s;
        nummaxIn = NUM_W'(nm);
        bitValid = v;
        bitIn    = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        bitValid = 1'b0;
    endtask

    // Streams one window of bits with random gaps. It returns one unit after
    // the edge that took the last bit, where the result must already be valid.
    task automatic streamBits(input logic [WIN-1:0] pattern, input int nm,
                              input int gapMax, input bit strayStart);
        sb.push_back(model(pattern, nm));
        for (int i = 0; i < WIN; i++) begin
            repeat ($urandom_range(gapMax, 0)) begin
                applyStimulus(strayStart ? 1'($urandom_range(1, 0)) : 1'b0,
                              int'($urandom_range(511, 0)), 1'b0,
                              1'($urandom_range(1, 0)));
            end
            applyStimulus(1'b0, int'($urandom_range(511, 0)), 1'b1, pattern[i]);
        end
        checkOutput("latency out_valid", int'(outValid), 1);
        checkOutput("latency out_valid round", int'(outValidR), 1);
    endtask

    // Monitor: compare each newly presented result against the queue head.
    initial begin : monitor
        bit      seen;
        expect_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !outValid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checkOutput("unexpected result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("count", int'(count), e.count);
                    checkOutput("value trunc", int'(value), e.value);
                    checkOutput("nummax_out", int'(nummaxOut), e.nummax);
                    checkOutput("count round", int'(countR), e.count);
                    checkOutput("value round", int'(valueR), e.valueR);
                    checkOutput("out_valid round", int'(outValidR), 1);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [WIN-1:0] pat;
        expect_t        e;
        int             nm;

        rst = 1'b1; start = 1'b0; nummaxIn = '0; bitIn = 1'b0;
        bitValid = 1'b0; outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset out_valid", int'(outValid), 0);
        checkOutput("reset count", int'(count), 0);
        checkOutput("reset value", int'(value), 0);
        checkOutput("reset nummax_out", int'(nummaxOut), 0);
        rst = 1'b0;

        // Full-scale stream; bits offered in IDLE must be ignored.
        applyStimulus(1'b0, 0, 1'b1, 1'b1);
        checkOutput("idle busy", int'(busy), 0);
        applyStimulus(1'b1, 256, 1'b0, 1'b0);
        checkOutput("start busy", int'(busy), 1);
        streamBits(16'hFFFF, 256, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("transfer busy", int'(busy), 0);

        // Exactly three ones with gaps: 300/16 truncates to 18, rounds to 19.
        do pat = WIN'($urandom_range(65535, 0)); while ($countones(pat) != 3);
        applyStimulus(1'b1, 100, 1'b0, 1'b0);
        streamBits(pat, 100, 3, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);

        // All-zero and alternating streams.
        applyStimulus(1'b1, 100, 1'b0, 1'b0);
        streamBits(16'h0000, 100, 2, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 100, 1'b0, 1'b0);
        streamBits(16'h5555, 100, 2, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);

        // Random windows.
        for (int w = 0; w < 6; w++) begin
            pat = WIN'($urandom_range(65535, 0));
            nm  = int'($urandom_range(511, 1));
            applyStimulus(1'b1, nm, 1'b0, 1'b0);
            streamBits(pat, nm, 2, 1'b1);
            applyStimulus(1'b0, 0, 1'b0, 1'b0);
        end

        // Backpressure: the held result must not move despite bits and start.
        outReady = 1'b0;
        pat = WIN'($urandom_range(65535, 0));
        nm  = int'($urandom_range(511, 1));
        e   = model(pat, nm);
        applyStimulus(1'b1, nm, 1'b0, 1'b0);
        streamBits(pat, nm, 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom_range(1, 0)), int'($urandom_range(511, 0)),
                          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            checkOutput("hold out_valid", int'(outValid), 1);
            checkOutput("hold busy", int'(busy), 1);
            checkOutput("hold count", int'(count), e.count);
            checkOutput("hold value", int'(value), e.value);
            checkOutput("hold value round", int'(valueR), e.valueR);
            checkOutput("hold nummax_out", int'(nummaxOut), e.nummax);
        end
        outReady = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("post-transfer out_valid", int'(outValid), 0);
        checkOutput("post-transfer busy", int'(busy), 0);
        checkOutput("post-transfer count kept", int'(count), e.count);
        checkOutput("post-transfer nummax kept", int'(nummaxOut), e.nummax);

        // Back-to-back windows: start in the transfer cycle.
        pat = WIN'($urandom_range(65535, 0));
        applyStimulus(1'b1, 200, 1'b0, 1'b0);
        streamBits(pat, 200, 1, 1'b0);
        applyStimulus(1'b1, 50, 1'b0, 1'b0);
        checkOutput("b2b busy", int'(busy), 1);
        checkOutput("b2b out_valid", int'(outValid), 0);
        streamBits(16'hFFFF, 50, 1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("b2b end busy", int'(busy), 0);

        // Reset after seven accepted ones discards the window.
        applyStimulus(1'b1, 123, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if ($urandom_range(1, 0) == 1) applyStimulus(1'b0, 0, 1'b0, 1'b1);
            applyStimulus(1'b0, 0, 1'b1, 1'b1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset out_valid", int'(outValid), 0);
        checkOutput("midreset count", int'(count), 0);
        checkOutput("midreset value", int'(value), 0);
        checkOutput("midreset value round", int'(valueR), 0);
        checkOutput("midreset nummax_out", int'(nummaxOut), 0);
        applyStimulus(1'b1, 77, 1'b0, 1'b0);
        streamBits(16'hFFFF, 77, 1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
